// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: opcode/handshake inputs and datapath control outputs of the multicycle MIPS controller
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       branch;
  logic       ir_write;
  logic       iord;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [1:0] alu_ctrl;
  logic [3:0] state;
  logic       mem_timeout;
  logic       illegal_op;
  modport master (
    input  opcode, mem_ready,
    output pc_write, branch, ir_write, iord, mem_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, pc_src, alu_ctrl, state, mem_timeout, illegal_op
  );
  modport slave (
    output opcode, mem_ready,
    input  pc_write, branch, ir_write, iord, mem_write, reg_write, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, pc_src, alu_ctrl, state, mem_timeout, illegal_op
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS main control FSM; define MIPS_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes
module mips_multicycle_control #(
  parameter int WAIT_LIMIT = 0
) (
  input logic clk,
  input logic rst_n,
  mips_multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, TRAP
  } state_t;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RT = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam state_t ILL_NXT =
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    TRAP;
`else
    FETCH;
`endif
  localparam int CW = $clog2(WAIT_LIMIT + 2);
  localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT);
  state_t st;
  logic [CW-1:0] cnt, cnt_nxt;
  logic stall, tmo;
  wire [5:0] op = bus.opcode;
  assign stall = (st == FETCH || st == MEMRD || st == MEMWR) && !bus.mem_ready;
  assign cnt_nxt = stall ? (&cnt ? cnt : cnt + 1'b1) : '0;
  assign bus.state = st;
  assign bus.mem_timeout = tmo;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  logic ill;
  assign bus.illegal_op = ill;
  // illegal flag latches once the FSM sits in TRAP
  always_ff @(posedge clk)
    if (!rst_n) ill <= 1'b0;
    else if (st == TRAP) ill <= 1'b1;
`else
  assign bus.illegal_op = 1'b0;
`endif
  // state sequencing, stall counter and sticky timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= IDLE;
      cnt <= '0;
      tmo <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (WAIT_LIMIT != 0 && cnt_nxt >= LIM) tmo <= 1'b1;
      case (st)
        IDLE:    st <= FETCH;
        FETCH:   st <= bus.mem_ready ? DECODE : FETCH;
        DECODE:  st <= (op == OP_LW || op == OP_SW) ? MEMADR :
                       op == OP_RT   ? RTYPEEX :
                       op == OP_BEQ  ? BEQEX :
                       op == OP_ADDI ? ADDIEX :
                       op == OP_J    ? JEX : ILL_NXT;
        MEMADR:  st <= op == OP_SW ? MEMWR : MEMRD;
        MEMRD:   st <= bus.mem_ready ? MEMWB : MEMRD;
        MEMWR:   st <= bus.mem_ready ? FETCH : MEMWR;
        RTYPEEX: st <= RTYPEWB;
        ADDIEX:  st <= ADDIWB;
        MEMWB, RTYPEWB, BEQEX, ADDIWB, JEX: st <= FETCH;
        TRAP:    st <= TRAP;
        default: st <= IDLE;
      endcase
    end
  end
  // per-state datapath controls; FETCH loads IR and PC as memory completes
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.branch     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.pc_src     = 2'b00;
    bus.alu_ctrl   = 2'b11;
    case (st)
      FETCH: begin
        bus.alu_src_b = 2'b01;
        bus.alu_ctrl  = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        bus.alu_ctrl  = 2'b01;
      end
      MEMADR, ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_ctrl  = 2'b01;
      end
      MEMRD: bus.iord = 1'b1;
      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
      end
      RTYPEEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctrl  = 2'b00;
      end
      RTYPEWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      BEQEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctrl  = 2'b10;
        bus.pc_src    = 2'b01;
        bus.branch    = 1'b1;
      end
      ADDIWB: bus.reg_write = 1'b1;
      JEX: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'b10;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS core.
- Decodes the 6-bit opcode from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives the datapath mux and write enables.
- Produces the 2-bit alu_ctrl code consumed by the ALU function decoder: 00 = use funct field, 01 = add, 10 = subtract, 11 = no operation.

Parameters:
WAIT_LIMIT, 0, consecutive memory stall cycles before mem_timeout is set; 0 disables the check.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous reset, active-low
opcode  in  6  instruction[31:26] from the IR; stable from DECODE onward
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
branch  out  1  PC load qualified by ALU zero
ir_write  out  1  IR load
iord  out  1  memory address source: 0 = PC, 1 = ALUOut
mem_write  out  1  memory write request
reg_write  out  1  register file write
reg_dst  out  1  destination register: 0 = rt, 1 = rd
mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A
alu_src_b  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2
pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
alu_ctrl  out  2  ALU operation class, encoded as in Overview
state  out  4  current state, for debug and verification
mem_timeout  out  1  sticky stall-timeout flag
illegal_op  out  1  sticky illegal-opcode flag (see Optional Feature)

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTYPEEX=7, RTYPEWB=8, BEQEX=9, ADDIEX=10, ADDIWB=11, JEX=12, TRAP=13. Codes 14 and 15 go to IDLE on the next cycle.
- Reset (rst_n=0 at a clk edge): state <= IDLE; mem_timeout <= 0; illegal_op <= 0; wait counter <= 0.
- IDLE: all outputs 0, alu_ctrl=11. Always goes to FETCH.
- Default in every state: each output not listed for that state is 0, and alu_ctrl=11.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=01, pc_src=00.
  - ir_write = pc_write = mem_ready (Mealy term).
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=01. Branches on opcode:
  - 100011 (LW) or 101011 (SW) -> MEMADR
  - 000000 (R-type) -> RTYPEEX
  - 000100 (BEQ) -> BEQEX
  - 001000 (ADDI) -> ADDIEX
  - 000010 (J) -> JEX
  - any other opcode -> illegal handling (see Optional Feature)
- MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl=01. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: iord=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEMWR: iord=1, mem_write=1, held for every cycle in the state. Goes to FETCH on mem_ready=1.
- RTYPEEX: alu_src_a=1, alu_src_b=00, alu_ctrl=00. Then RTYPEWB.
- RTYPEWB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BEQEX: alu_src_a=1, alu_src_b=00, alu_ctrl=10, pc_src=01, branch=1. Then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=01. Then ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- JEX: pc_write=1, pc_src=10. Then FETCH.
- Latency with zero stalls, FETCH to the next FETCH: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3 cycles.
- Wait counter:
  - Increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0; saturates at its maximum.
  - Clears on mem_ready=1 and on any state change.
  - If WAIT_LIMIT != 0 and the count reaches WAIT_LIMIT, mem_timeout <= 1 and stays set until reset.
  - mem_timeout never alters FSM flow.
- mem_ready is ignored in all states except FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction: the next state is IDLE regardless of mem_ready. No write enable is asserted in the cycle after reset.

Optional Feature:
- Macro MIPS_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unrecognised opcode in DECODE goes to TRAP.
  - TRAP drives all outputs 0 with alu_ctrl=11, sets illegal_op <= 1, and stays in TRAP until reset.
- Undefined:
  - An unrecognised opcode goes from DECODE to FETCH, so the instruction behaves as a NOP (the PC was already incremented in FETCH).
  - illegal_op is tied to 0 and TRAP is unreachable.

Test Plan:
- Reset, then opcode=000000 with mem_ready=1 constant -> state sequence 0,1,2,7,8,1. alu_ctrl=00 in RTYPEEX. reg_write=1 and reg_dst=1 in RTYPEWB only.
- LW (100011) with mem_ready low for 3 cycles in MEMRD -> MEMRD lasts 4 cycles. reg_write=1 and mem_to_reg=1 for exactly one cycle. alu_ctrl=01 in MEMADR.
- SW (101011) with mem_ready=1 -> mem_write=1 for exactly one cycle in MEMWR, then FETCH. Instruction takes 4 cycles.
- BEQ (000100) then J (000010) -> BEQEX: alu_ctrl=10, branch=1, pc_src=01. JEX: pc_write=1, pc_src=10. Each instruction takes 3 cycles.
- WAIT_LIMIT=4, mem_ready held 0 in FETCH for 6 cycles -> mem_timeout rises in the cycle after the 4th stall cycle and stays 1. pc_write pulses once when mem_ready rises.
- opcode=111111: with the macro defined -> state 13 and illegal_op=1 until rst_n=0. Without the macro -> DECODE then FETCH, illegal_op=0. In both builds, rst_n=0 asserted in MEMRD -> state=0 next cycle.
